// File: rtl/chimera_reg_to_apb_pkg.sv
// chimera_reg_to_apb_pkg
//   Shared constants and types for the external configuration APB bridge.
//   The external config region is split into 4 KiB windows, one per APB
//   peripheral: pads, FLLs, PMU controller (in that order).
package chimera_reg_to_apb_pkg;

  localparam int unsigned ExtCfgApbNumSlv  = 3;
  localparam int unsigned PadCfgApbIdx     = 0;
  localparam int unsigned FllCfgApbIdx     = 1;
  localparam int unsigned PmuCfgApbIdx     = 2;
  localparam int unsigned ExtCfgApbTimeout = 255;
  localparam logic [31:0] ExtCfgApbBase    = 32'h3000_2000;

  // log2 of the per-peripheral window size (4 KiB)
  localparam int unsigned ApbWinShift = 12;

  typedef enum logic [1:0] {
    ApbIdle,
    ApbSetup,
    ApbAccess,
    ApbResp
  } extCfgApbState_e;

endpackage

// File: rtl/chimera_reg_to_apb_if.sv
// Bus interfaces for chimera_reg_to_apb.
//   chimera_reg_to_apb_reg_if : register-bus request/response.
//     master = requester (SoC demux), slave = bridge.
//   chimera_reg_to_apb_apb_if : APB4 bus with one PSEL per peripheral.
//     master = bridge, slave = peripherals.
//   Signal names keep the bridge-side direction suffixes so the bridge
//   view reads like its port list.
interface chimera_reg_to_apb_reg_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  logic                   reg_valid_i;
  logic                   reg_write_i;
  logic [AddrWidth-1:0]   reg_addr_i;
  logic [DataWidth-1:0]   reg_wdata_i;
  logic [DataWidth/8-1:0] reg_wstrb_i;
  logic                   reg_ready_o;
  logic [DataWidth-1:0]   reg_rdata_o;
  logic                   reg_error_o;

  modport master (
    output reg_valid_i, reg_write_i, reg_addr_i, reg_wdata_i, reg_wstrb_i,
    input  reg_ready_o, reg_rdata_o, reg_error_o
  );
  modport slave (
    input  reg_valid_i, reg_write_i, reg_addr_i, reg_wdata_i, reg_wstrb_i,
    output reg_ready_o, reg_rdata_o, reg_error_o
  );
endinterface

interface chimera_reg_to_apb_apb_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumApbSlv = 3
);
  logic [AddrWidth-1:0]                paddr_o;
  logic [2:0]                          pprot_o;
  logic [NumApbSlv-1:0]                psel_o;
  logic                                penable_o;
  logic                                pwrite_o;
  logic [DataWidth-1:0]                pwdata_o;
  logic [DataWidth/8-1:0]              pstrb_o;
  logic [NumApbSlv-1:0]                pready_i;
  logic [NumApbSlv-1:0][DataWidth-1:0] prdata_i;
  logic [NumApbSlv-1:0]                pslverr_i;

  modport master (
    output paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
    input  pready_i, prdata_i, pslverr_i
  );
  modport slave (
    input  paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
    output pready_i, prdata_i, pslverr_i
  );
endinterface

// File: rtl/chimera_reg_to_apb.sv
// chimera_reg_to_apb
//   Register-bus slave -> APB4 master for the external config region.
//   Each 4 KiB window above BaseAddr maps to one PSEL. Unmapped addresses
//   complete with an error and no APB activity; a peripheral that never
//   raises PREADY is cut off after TimeoutCycles ACCESS cycles (0 = never).
// Ports
//   clk_i, rst_ni : clock, async active-low reset
//   regIf         : register-bus slave side (request held until ready pulse)
//   apbIf         : APB4 master side, one-hot psel_o
module chimera_reg_to_apb
  import chimera_reg_to_apb_pkg::*;
#(
  parameter int unsigned          AddrWidth     = 32,
  parameter int unsigned          DataWidth     = 32,
  parameter int unsigned          NumApbSlv     = ExtCfgApbNumSlv,
  parameter logic [AddrWidth-1:0] BaseAddr      = AddrWidth'(ExtCfgApbBase),
  parameter int unsigned          TimeoutCycles = ExtCfgApbTimeout
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  chimera_reg_to_apb_reg_if.slave  regIf,
  chimera_reg_to_apb_apb_if.master apbIf
);

  localparam int unsigned StrbWidth   = DataWidth / 8;
  localparam int unsigned IdxWidth    = (NumApbSlv > 1) ? $clog2(NumApbSlv) : 1;
  localparam int unsigned CntWidth    = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam int unsigned TimeoutLast = (TimeoutCycles == 0) ? 0 : TimeoutCycles - 1;

  // Decode on one extra bit so BaseAddr + window span cannot wrap.
  logic [AddrWidth:0]   reqAddrExt, winLo, winHi;
  logic [AddrWidth-1:0] winOff;
  logic                 mapped;
  logic [IdxWidth-1:0]  decIdx;
  logic [NumApbSlv-1:0] decSel;

  assign reqAddrExt = {1'b0, regIf.reg_addr_i};
  assign winLo      = {1'b0, BaseAddr};
  assign winHi      = winLo + ((AddrWidth + 1)'(NumApbSlv) << ApbWinShift);
  assign mapped     = (reqAddrExt >= winLo) && (reqAddrExt < winHi);
  assign winOff     = regIf.reg_addr_i - BaseAddr;
  assign decIdx     = winOff[ApbWinShift +: IdxWidth];

  always_comb begin
    decSel         = '0;
    decSel[decIdx] = 1'b1;
  end

  extCfgApbState_e      state;
  logic [IdxWidth-1:0]  idxQ;
  logic [CntWidth-1:0]  cnt;
  logic [NumApbSlv-1:0] pselQ;
  logic                 penableQ;
  logic [AddrWidth-1:0] paddrQ;
  logic                 pwriteQ;
  logic [DataWidth-1:0] pwdataQ;
  logic [StrbWidth-1:0] pstrbQ;
  logic                 readyQ;
  logic [DataWidth-1:0] rdataQ;
  logic                 errorQ;

  // Only the latched slave index is ever looked at on the response side.
  logic                 selReady, selErr, timeoutHit;
  logic [DataWidth-1:0] selRdata;

  assign selReady   = apbIf.pready_i[idxQ];
  assign selErr     = apbIf.pslverr_i[idxQ];
  assign selRdata   = apbIf.prdata_i[idxQ];
  assign timeoutHit = (TimeoutCycles != 0) && (cnt == CntWidth'(TimeoutLast));

  // The APB output registers double as the latched request: they are
  // loaded on acceptance and held untouched through SETUP and ACCESS.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ApbIdle;
      idxQ     <= '0;
      cnt      <= '0;
      pselQ    <= '0;
      penableQ <= 1'b0;
      paddrQ   <= '0;
      pwriteQ  <= 1'b0;
      pwdataQ  <= '0;
      pstrbQ   <= '0;
      readyQ   <= 1'b0;
      rdataQ   <= '0;
      errorQ   <= 1'b0;
    end else begin
      case (state)
        ApbIdle: begin
          if (regIf.reg_valid_i) begin
            if (mapped) begin
              state   <= ApbSetup;
              idxQ    <= decIdx;
              pselQ   <= decSel;
              paddrQ  <= {regIf.reg_addr_i[AddrWidth-1:2], 2'b00};
              pwriteQ <= regIf.reg_write_i;
              pwdataQ <= regIf.reg_wdata_i;
              pstrbQ  <= regIf.reg_write_i ? regIf.reg_wstrb_i : '0;
            end else begin
              state  <= ApbResp;
              readyQ <= 1'b1;
              rdataQ <= '0;
              errorQ <= 1'b1;
            end
          end
        end
        ApbSetup: begin
          state    <= ApbAccess;
          penableQ <= 1'b1;
        end
        ApbAccess: begin
          cnt <= cnt + 1'b1;
          // PREADY wins over a timeout landing on the same cycle.
          if (selReady || timeoutHit) begin
            state    <= ApbResp;
            readyQ   <= 1'b1;
            rdataQ   <= (selReady && !pwriteQ) ? selRdata : '0;
            errorQ   <= selReady ? selErr : 1'b1;
            pselQ    <= '0;
            penableQ <= 1'b0;
            paddrQ   <= '0;
            pwriteQ  <= 1'b0;
            pwdataQ  <= '0;
            pstrbQ   <= '0;
          end
        end
        ApbResp: begin
          state  <= ApbIdle;
          readyQ <= 1'b0;
          rdataQ <= '0;
          errorQ <= 1'b0;
          cnt    <= '0;
        end
        default: state <= ApbIdle;
      endcase
    end
  end

  assign regIf.reg_ready_o = readyQ;
  assign regIf.reg_rdata_o = rdataQ;
  assign regIf.reg_error_o = errorQ;

  assign apbIf.paddr_o   = paddrQ;
  assign apbIf.pprot_o   = 3'b000;
  assign apbIf.psel_o    = pselQ;
  assign apbIf.penable_o = penableQ;
  assign apbIf.pwrite_o  = pwriteQ;
  assign apbIf.pwdata_o  = pwdataQ;
  assign apbIf.pstrb_o   = pstrbQ;

endmodule

// File: tb/tb_chimera_reg_to_apb.sv
// tb_chimera_reg_to_apb
//   Directed bench. Each transfer's cycle-by-cycle expectation is derived
//   from the protocol timeline (accept, SETUP, ACCESS until ready/timeout,
//   RESP) and checked on every negedge; literal checks pin latencies and
//   captured values per scenario.
module tb_chimera_reg_to_apb;

  localparam logic [31:0] BASE = 32'h3000_2000;
  localparam int          TO   = 255;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        err;
    logic [2:0]  psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } expT;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  chimera_reg_to_apb_reg_if #(.AddrWidth(32), .DataWidth(32)) regIf ();
  chimera_reg_to_apb_apb_if #(.AddrWidth(32), .DataWidth(32), .NumApbSlv(3)) apbIf ();

  chimera_reg_to_apb #(
    .AddrWidth(32), .DataWidth(32), .NumApbSlv(3),
    .BaseAddr(BASE), .TimeoutCycles(TO)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .regIf (regIf.slave),
    .apbIf (apbIf.master)
  );

  int  nAssert = 0;
  int  nFail   = 0;
  int  cyc     = 0;
  bit  chkEn   = 1'b0;
  expT exp;

  // observations gathered per transfer for the literal checks
  int          startCyc, readyCyc, accCnt;
  bit          seenReady;
  logic [31:0] gotRdata, gotPaddr;
  logic        gotErr;
  logic [2:0]  pselSeen;
  logic [3:0]  gotPstrb;

  always @(posedge clk_i) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    nAssert++;
    if (act !== expv) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // single per-cycle compare process
  always @(negedge clk_i) begin
    if (chkEn) begin
      chk("ready", 64'(regIf.reg_ready_o), 64'(exp.ready));
      chk("rdata", 64'(regIf.reg_rdata_o), 64'(exp.rdata));
      chk("error", 64'(regIf.reg_error_o), 64'(exp.err));
      chk("psel", 64'(apbIf.psel_o), 64'(exp.psel));
      chk("penable", 64'(apbIf.penable_o), 64'(exp.penable));
      chk("pprot", 64'(apbIf.pprot_o), 64'd0);
      if (exp.psel != 3'b000) begin
        chk("paddr", 64'(apbIf.paddr_o), 64'(exp.paddr));
        chk("pwrite", 64'(apbIf.pwrite_o), 64'(exp.pwrite));
        chk("pwdata", 64'(apbIf.pwdata_o), 64'(exp.pwdata));
        chk("pstrb", 64'(apbIf.pstrb_o), 64'(exp.pstrb));
      end
      if (regIf.reg_ready_o && !seenReady) begin
        seenReady = 1'b1;
        readyCyc  = cyc;
        gotRdata  = regIf.reg_rdata_o;
        gotErr    = regIf.reg_error_o;
      end
      if (apbIf.penable_o) accCnt++;
      if (apbIf.psel_o != 3'b000) begin
        gotPaddr = apbIf.paddr_o;
        gotPstrb = apbIf.pstrb_o;
      end
      pselSeen |= apbIf.psel_o;
    end
  end

  task automatic nextCyc();
    @(posedge clk_i);
    #1;
  endtask

  function automatic expT idleExp();
    expT e;
    e = '0;
    return e;
  endfunction

  function automatic expT respExp(input logic err, input logic [31:0] rd);
    expT e;
    e       = '0;
    e.ready = 1'b1;
    e.err   = err;
    e.rdata = rd;
    return e;
  endfunction

  // unselected slaves shout ready/error with junk data; the bridge must ignore them
  task automatic apbNoise();
    apbIf.pready_i  = 3'b111;
    apbIf.pslverr_i = 3'b111;
    for (int k = 0; k < 3; k++) apbIf.prdata_i[k] = 32'hBAD0_0000 + 32'(k);
  endtask

  // Entered at posedge+1 of an IDLE cycle, returns at posedge+1 of the
  // IDLE cycle after the response. waitCyc<0 means the slave never answers.
  task automatic doXfer(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, input int waitCyc,
                        input logic [31:0] rd, input bit serr);
    longint a      = longint'(addr);
    bit     mapped = (a >= longint'(BASE)) && (a < longint'(BASE) + 3 * 4096);
    int     idx    = mapped ? int'((a - longint'(BASE)) >>> 12) : 0;
    bit     hit    = 1'b0;
    bit     done   = 1'b0;
    expT    bus;
    startCyc  = cyc;
    seenReady = 1'b0;
    accCnt    = 0;
    pselSeen  = '0;
    regIf.reg_valid_i = 1'b1;
    regIf.reg_write_i = wr;
    regIf.reg_addr_i  = addr;
    regIf.reg_wdata_i = wd;
    regIf.reg_wstrb_i = strb;
    exp = idleExp();
    apbNoise();
    nextCyc();
    // request is latched now; garbage on the inputs must not leak through
    regIf.reg_write_i = !wr;
    regIf.reg_addr_i  = addr ^ 32'h0000_1FFC;
    regIf.reg_wdata_i = ~wd;
    regIf.reg_wstrb_i = ~strb;
    if (!mapped) begin
      exp = respExp(1'b1, 32'h0);
    end else begin
      bus        = '0;
      bus.psel   = 3'(1 << idx);
      bus.paddr  = addr & 32'hFFFF_FFFC;
      bus.pwrite = wr;
      bus.pwdata = wd;
      bus.pstrb  = wr ? strb : 4'h0;
      exp = bus;
      apbIf.pready_i[idx]  = 1'b0;
      apbIf.prdata_i[idx]  = rd;
      apbIf.pslverr_i[idx] = serr;
      nextCyc();
      for (int j = 0; j < TO && !done; j++) begin
        exp         = bus;
        exp.penable = 1'b1;
        hit = (j == waitCyc);
        apbIf.pready_i[idx] = hit;
        done = hit || (j == TO - 1);
        nextCyc();
      end
      apbNoise();
      exp = hit ? respExp(serr, wr ? 32'h0 : rd) : respExp(1'b1, 32'h0);
    end
    nextCyc();
  endtask

  task automatic idle(input int n);
    regIf.reg_valid_i = 1'b0;
    exp = idleExp();
    apbNoise();
    repeat (n) nextCyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r1;
    regIf.reg_valid_i = 1'b0;
    regIf.reg_write_i = 1'b0;
    regIf.reg_addr_i  = '0;
    regIf.reg_wdata_i = '0;
    regIf.reg_wstrb_i = '0;
    apbNoise();
    exp = idleExp();

    // reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst ready", 64'(regIf.reg_ready_o), 64'd0);
    chk("rst psel", 64'(apbIf.psel_o), 64'd0);
    chk("rst penable", 64'(apbIf.penable_o), 64'd0);
    chk("rst paddr", 64'(apbIf.paddr_o), 64'd0);
    @(negedge clk_i) rst_ni = 1'b1;
    nextCyc();
    chkEn = 1'b1;
    idle(2);

    // read, slave 1 ready on first ACCESS cycle
    doXfer(1'b0, 32'h3000_3004, 32'h1111_2222, 4'hF, 0, 32'hDEAD_BEEF, 1'b0);
    chk("t1 latency", 64'(readyCyc - startCyc), 64'd3);
    chk("t1 rdata", 64'(gotRdata), 64'hDEAD_BEEF);
    chk("t1 err", 64'(gotErr), 64'd0);
    chk("t1 psel", 64'(pselSeen), 64'b010);
    chk("t1 pstrb", 64'(gotPstrb), 64'h0);
    idle(1);

    // write, slave 0 waits 4 cycles
    doXfer(1'b1, 32'h3000_2010, 32'h1234_5678, 4'b0011, 4, 32'h5555_AAAA, 1'b0);
    chk("t2 latency", 64'(readyCyc - startCyc), 64'd7);
    chk("t2 access cycles", 64'(accCnt), 64'd5);
    chk("t2 pstrb", 64'(gotPstrb), 64'b0011);
    chk("t2 rdata", 64'(gotRdata), 64'h0);
    chk("t2 err", 64'(gotErr), 64'd0);
    idle(1);

    // unmapped: just past the top, then just below the base, back-to-back
    doXfer(1'b0, 32'h3000_5000, 32'h0, 4'h0, 0, 32'h0, 1'b0);
    chk("t3a latency", 64'(readyCyc - startCyc), 64'd1);
    chk("t3a err", 64'(gotErr), 64'd1);
    chk("t3a psel", 64'(pselSeen), 64'd0);
    doXfer(1'b1, 32'h3000_1FFC, 32'hFFFF_FFFF, 4'hF, 0, 32'h0, 1'b0);
    chk("t3b latency", 64'(readyCyc - startCyc), 64'd1);
    chk("t3b err", 64'(gotErr), 64'd1);
    chk("t3b rdata", 64'(gotRdata), 64'h0);
    chk("t3b psel", 64'(pselSeen), 64'd0);
    idle(1);

    // slave 2 hangs -> timeout, then a normal request
    doXfer(1'b0, 32'h3000_4008, 32'h0, 4'h0, -1, 32'h7777_7777, 1'b0);
    chk("t4 access cycles", 64'(accCnt), 64'd255);
    chk("t4 latency", 64'(readyCyc - startCyc), 64'd257);
    chk("t4 err", 64'(gotErr), 64'd1);
    chk("t4 rdata", 64'(gotRdata), 64'h0);
    idle(1);
    doXfer(1'b0, 32'h3000_2000, 32'h0, 4'h0, 1, 32'hA5A5_0001, 1'b0);
    chk("t4b latency", 64'(readyCyc - startCyc), 64'd4);
    chk("t4b rdata", 64'(gotRdata), 64'hA5A5_0001);
    idle(1);

    // slave error on read keeps the read data
    doXfer(1'b0, 32'h3000_4000, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 1'b1);
    chk("t5 err", 64'(gotErr), 64'd1);
    chk("t5 rdata", 64'(gotRdata), 64'hCAFE_F00D);
    chk("t5 psel", 64'(pselSeen), 64'b100);
    idle(1);

    // async reset in ACCESS
    chkEn = 1'b0;
    regIf.reg_valid_i = 1'b1;
    regIf.reg_write_i = 1'b0;
    regIf.reg_addr_i  = 32'h3000_4000;
    apbNoise();
    apbIf.pready_i = 3'b011;
    repeat (3) nextCyc();
    chk("t6 pre psel", 64'(apbIf.psel_o), 64'b100);
    chk("t6 pre penable", 64'(apbIf.penable_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("t6 rst psel", 64'(apbIf.psel_o), 64'd0);
    chk("t6 rst penable", 64'(apbIf.penable_o), 64'd0);
    chk("t6 rst paddr", 64'(apbIf.paddr_o), 64'd0);
    chk("t6 rst ready", 64'(regIf.reg_ready_o), 64'd0);
    regIf.reg_valid_i = 1'b0;
    @(negedge clk_i) rst_ni = 1'b1;
    nextCyc();
    exp = idleExp();
    apbNoise();
    chkEn = 1'b1;
    nextCyc();
    doXfer(1'b0, 32'h3000_3FFE, 32'h0, 4'h0, 2, 32'h0BAD_CAFE, 1'b0);
    chk("t6 latency", 64'(readyCyc - startCyc), 64'd5);
    chk("t6 rdata", 64'(gotRdata), 64'h0BAD_CAFE);
    chk("t6 paddr", 64'(gotPaddr), 64'h3000_3FFC);
    idle(1);

    // back-to-back: one IDLE cycle between RESP and next SETUP
    doXfer(1'b1, 32'h3000_2100, 32'hAAAA_0001, 4'b1000, 0, 32'h0, 1'b0);
    r1 = readyCyc;
    doXfer(1'b0, 32'h3000_3200, 32'h0, 4'h0, 0, 32'h1357_9BDF, 1'b0);
    chk("b2b gap", 64'(startCyc - r1), 64'd1);
    chk("b2b latency", 64'(readyCyc - startCyc), 64'd3);
    chk("b2b rdata", 64'(gotRdata), 64'h1357_9BDF);
    doXfer(1'b0, 32'h3000_4FFC, 32'h0, 4'h0, 1, 32'h2468_ACE0, 1'b1);
    chk("b2b3 err", 64'(gotErr), 64'd1);
    chk("b2b3 rdata", 64'(gotRdata), 64'h2468_ACE0);
    idle(3);

    chkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
